// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//   Produces the sixteen 48-bit DES round subkeys from a 64-bit key, one per
//   valid/ready handshake. The order is encrypt (K1..K16) or decrypt (K16..K1).
//   subkey[47:42] feeds S1 and subkey[5:0] feeds S8.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   key_valid    : key_in/decrypt valid (accepted only while key_ready)
//   key_ready    : high in IDLE only
//   key_in[63:0] : DES key, FIPS bit 1 = key_in[63]; parity bits ignored
//   decrypt      : sampled at key accept, 1 = K16..K1 order
//   subkey_valid : subkey valid (high in RUN)
//   subkey_ready : consumer accepts the current subkey
//   subkey[47:0] : PC-2(C,D), FIPS bit 1 = subkey[47]
//   round_idx    : 0-based emission position (not the K index)
//   last         : high with the 16th emitted subkey
//   busy         : high in RUN
// -----------------------------------------------------------------------------
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        last,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // FIPS 1-based bit numbers of the key selected into C0||D0.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // FIPS 1-based bit numbers of C||D selected into the subkey.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit i set means the shift for K(i+1) is 1; all other rounds shift by 2.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] r;
    cd = {c, d};
    r  = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  // Rotations stay inside one 28-bit half; FIPS bit 1 of a half is bit [27].
  function automatic logic [27:0] rol(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] ror(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  logic [0:0]  state;
  logic        dir;
  logic [27:0] c_reg, d_reg;
  logic [55:0] cd0;
  logic [3:0]  sched_idx;
  logic        shift_one;

  // NOTE: combinational blocks assign every output first so no latch is inferred.
  always_comb begin
    cd0       = pc1_perm(key_in);
    // Encrypt steps towards K(r+2); decrypt walks back from C16 = C0.
    sched_idx = dir ? (4'd15 - round_idx) : (round_idx + 4'd1);
    shift_one = SHIFT_ONE[sched_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir       <= 1'b0;
      round_idx <= 4'd0;
      c_reg     <= '0;
      d_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            state     <= RUN;
            dir       <= decrypt;
            round_idx <= 4'd0;
            // Encrypt starts at C1/D1; decrypt starts at C0/D0 which equals C16/D16.
            c_reg     <= decrypt ? cd0[55:28] : rol(cd0[55:28], 1'b1);
            d_reg     <= decrypt ? cd0[27:0]  : rol(cd0[27:0],  1'b1);
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (round_idx == 4'd15) begin
              state <= IDLE;
            end else begin
              round_idx <= round_idx + 4'd1;
              c_reg     <= dir ? ror(c_reg, shift_one) : rol(c_reg, shift_one);
              d_reg     <= dir ? ror(d_reg, shift_one) : rol(d_reg, shift_one);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_ready    = (state == IDLE);
  assign busy         = (state == RUN);
  assign subkey_valid = (state == RUN);
  assign last         = (state == RUN) && (round_idx == 4'd15);
  assign subkey       = pc2_perm(c_reg, d_reg);

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
//   Self-checking bench for des_key_schedule. Expected subkeys come from a
//   FIPS-indexed reference model (cumulative rotation from C0/D0) and from the
//   published vector values; they are queued at key accept and popped on each
//   subkey handshake.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        decrypt;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        last;
  logic        busy;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .last         (last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h123456789ABCDEF0;
  localparam logic [63:0] KEY_B   = 64'h0123456789ABCDEF;

  int checks = 0;
  int errors = 0;

  logic [47:0] exp_q [$];
  logic [47:0] got_seq [16];
  logic [47:0] enc_seq [16];
  logic [47:0] dec_seq [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Kn from the key using 1-based FIPS numbering throughout.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    bit kb  [1:64];
    bit cd  [1:56];
    bit cdn [1:56];
    int s;
    logic [47:0] r;
    for (int i = 1; i <= 64; i++) kb[i] = key[64-i];
    for (int i = 1; i <= 56; i++) cd[i] = kb[PC1_T[i-1]];
    s = 0;
    for (int j = 0; j < n; j++) s += SCHED[j];
    for (int i = 1; i <= 28; i++) begin
      cdn[i]    = cd[((i - 1 + s) % 28) + 1];
      cdn[i+28] = cd[((i - 1 + s) % 28) + 29];
    end
    r = '0;
    for (int i = 1; i <= 48; i++) r[48-i] = cdn[PC2_T[i-1]];
    return r;
  endfunction

  // One key sequence. bp: random backpressure; pulse_cyc: cycle after accept
  // to pulse a foreign key (-1 none); rst_at: emission index at which reset
  // is asserted (-1 none).
  task automatic run_seq(input logic [63:0] key, input logic dec, input bit bp,
                         input int pulse_cyc, input int rst_at, input string name);
    int          cyc;
    int          accepted;
    int          waited;
    bit          stalled_prev;
    logic [47:0] held_key;
    logic [3:0]  held_idx;
    logic        held_last;
    logic [47:0] e;

    waited = 0;
    @(negedge clk);
    while (!key_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_key_ready_idle"}, key_ready, 1'b1);
    key_valid    = 1'b1;
    key_in       = key;
    decrypt      = dec;
    subkey_ready = 1'b1;
    exp_q.delete();
    for (int n = 0; n < 16; n++) exp_q.push_back(ref_subkey(key, dec ? 16 - n : n + 1));

    @(negedge clk);
    // Direction and key must be latched at accept, not followed afterwards.
    key_valid    = 1'b0;
    key_in       = {$urandom, $urandom};
    decrypt      = ~dec;
    cyc          = 1;
    accepted     = 0;
    stalled_prev = 1'b0;
    check({name, "_valid_at_t1"}, subkey_valid, 1'b1);

    while (accepted < 16 && cyc < 300) begin
      if (rst_at >= 0 && accepted == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({name, "_rst_valid"}, subkey_valid, 1'b0);
        check({name, "_rst_key_ready"}, key_ready, 1'b1);
        check({name, "_rst_round_idx"}, round_idx, 4'd0);
        check({name, "_rst_subkey"}, subkey, 48'h0);
        @(negedge clk);
        check({name, "_rst_held_idle"}, busy, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      subkey_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cyc == pulse_cyc) begin
        key_valid = 1'b1;
        key_in    = KEY_B;
        check({name, "_busy_key_ready"}, key_ready, 1'b0);
      end else begin
        key_valid = 1'b0;
      end
      if (stalled_prev) begin
        check({name, "_stall_subkey"}, subkey, held_key);
        check({name, "_stall_idx"}, round_idx, held_idx);
        check({name, "_stall_last"}, last, held_last);
      end
      check({name, "_valid"}, subkey_valid, 1'b1);
      held_key  = subkey;
      held_idx  = round_idx;
      held_last = last;
      if (subkey_ready) begin
        e = exp_q.pop_front();
        check({name, "_subkey"}, subkey, e);
        check({name, "_round_idx"}, round_idx, accepted[3:0]);
        check({name, "_last"}, last, accepted == 15);
        if (!bp) check({name, "_latency"}, cyc, accepted + 1);
        got_seq[accepted] = subkey;
        accepted++;
      end
      stalled_prev = !subkey_ready;
      @(negedge clk);
      cyc++;
    end
    key_valid    = 1'b0;
    subkey_ready = 1'b0;
    check({name, "_all_accepted"}, accepted, 16);
    check({name, "_done_key_ready"}, key_ready, 1'b1);
    check({name, "_done_valid"}, subkey_valid, 1'b0);
    check({name, "_done_busy"}, busy, 1'b0);
    if (!bp) check({name, "_ready_at_t17"}, cyc, 17);
  endtask

  initial begin
    rst_n        = 1'b0;
    key_valid    = 1'b0;
    key_in       = '0;
    decrypt      = 1'b0;
    subkey_ready = 1'b0;
    #1;
    check("reset_key_ready", key_ready, 1'b1);
    check("reset_valid", subkey_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_last", last, 1'b0);
    check("reset_round_idx", round_idx, 4'd0);
    check("reset_subkey", subkey, 48'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Encrypt vector.
    run_seq(KEY_A, 1'b0, 1'b0, -1, -1, "enc");
    for (int i = 0; i < 16; i++) enc_seq[i] = got_seq[i];
    check("enc_k1_const", enc_seq[0], 48'h1B02EFFC7072);
    check("enc_k2_const", enc_seq[1], 48'h79AED9DBC9E5);
    check("enc_k16_const", enc_seq[15], 48'hCB3D8B0E17F5);

    // Decrypt vector.
    run_seq(KEY_A, 1'b1, 1'b0, -1, -1, "dec");
    for (int i = 0; i < 16; i++) dec_seq[i] = got_seq[i];
    check("dec_first_const", dec_seq[0], 48'hCB3D8B0E17F5);
    check("dec_15th_const", dec_seq[14], 48'h79AED9DBC9E5);
    check("dec_16th_const", dec_seq[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) check("dec_reversed", dec_seq[i], enc_seq[15-i]);

    // Backpressure.
    run_seq(KEY_A, 1'b0, 1'b1, -1, -1, "bp");
    for (int i = 0; i < 16; i++) check("bp_same_seq", got_seq[i], enc_seq[i]);

    // Busy rejection of a foreign key at T+5.
    run_seq(KEY_A, 1'b0, 1'b0, 5, -1, "busy");
    for (int i = 0; i < 16; i++) check("busy_same_seq", got_seq[i], enc_seq[i]);

    // Parity bits ignored.
    run_seq(KEY_PAR, 1'b0, 1'b0, -1, -1, "par");
    for (int i = 0; i < 16; i++) check("par_same_seq", got_seq[i], enc_seq[i]);

    // Reset while the 7th subkey is presented, then a fresh key.
    run_seq(KEY_A, 1'b0, 1'b0, -1, 6, "rst");
    run_seq(KEY_B, 1'b0, 1'b0, -1, -1, "post_rst");
    run_seq(KEY_B, 1'b1, 1'b1, -1, -1, "post_rst_dec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp %0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
